// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the M-extension divide controller:
// func3 encodings, FSM state type, overflow constants and result selection.
package div_ctrl_pkg;

    localparam logic [2:0] FUNC3_DIV  = 3'b100;
    localparam logic [2:0] FUNC3_DIVU = 3'b101;
    localparam logic [2:0] FUNC3_REM  = 3'b110;
    localparam logic [2:0] FUNC3_REMU = 3'b111;

    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        WB        = 3'd4
    } div_state_t;

    // func3[1] distinguishes REM/REMU (remainder) from DIV/DIVU (quotient)
    function automatic logic [31:0] pick_result(input logic [2:0]  f3,
                                                input logic [31:0] quot,
                                                input logic [31:0] rem);
        logic [31:0] res;
        if (f3[1]) begin
            res = rem;
        end else begin
            res = quot;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Sequencer between the EX stage and an external iterative divider: fast paths for
// divide-by-zero, signed overflow and a one-entry result cache, plus busy/done timeouts.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int BUSY_WAIT_MAX = 4,
    parameter int DONE_WAIT_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  func3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [4:0]  rd_addr,
    input  logic        flush,
    output logic        hold_req,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        div_err,
    output logic        div_en,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic [2:0]  div_func3,
    input  logic        div_busy,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem
);

    localparam int CNT_MAX = (DONE_WAIT_MAX > BUSY_WAIT_MAX) ? DONE_WAIT_MAX : BUSY_WAIT_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_WAIT_MAX - 1);

    div_state_t       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [4:0]       rd_addr_r;

    logic        cache_valid_r;
    logic [31:0] cache_op1_r, cache_op2_r, cache_quot_r, cache_rem_r;
    logic        cache_unsigned_r;

    logic        take_s, zero_s, ovf_s, hit_s, fast_s, waiting_s;
    logic [31:0] fast_quot_s, fast_rem_s;
    logic        div_en_s, wb_we_s, div_err_s, cache_wr_s, cache_inv_s;
    logic [4:0]  wb_addr_s;
    logic [31:0] wb_data_s;

    // Fast-path detection works on the live request so the result is ready in one cycle
    assign take_s    = (state_r == IDLE) && req_valid && !flush;
    assign zero_s    = (op2 == 32'h0000_0000);
    assign ovf_s     = !func3[0] && (op1 == OVF_DIVIDEND) && (op2 == ALL_ONES);
    assign hit_s     = cache_valid_r && (op1 == cache_op1_r) && (op2 == cache_op2_r)
                       && (func3[0] == cache_unsigned_r);
    assign fast_s    = zero_s || ovf_s || hit_s;
    assign waiting_s = (state_r == ISSUE) || (state_r == WAIT_BUSY) || (state_r == WAIT_DONE);

    // Stall is combinational so the pipeline freezes in the request cycle; forced low in reset
    assign hold_req  = rst && (waiting_s || ((state_r == IDLE) && req_valid && !flush));

    // Fast-path result: divide-by-zero first, then signed overflow, then cached entry
    always_comb begin
        fast_quot_s = cache_quot_r;
        fast_rem_s  = cache_rem_r;
        if (zero_s) begin
            fast_quot_s = ALL_ONES;
            fast_rem_s  = op1;
        end else if (ovf_s) begin
            fast_quot_s = OVF_DIVIDEND;
            fast_rem_s  = 32'h0000_0000;
        end else begin
            fast_quot_s = cache_quot_r;
            fast_rem_s  = cache_rem_r;
        end
    end

    // Next-state and next-output decode; write-back outputs are registered on entry to WB
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        div_en_s    = 1'b0;
        wb_we_s     = 1'b0;
        wb_addr_s   = 5'd0;
        wb_data_s   = 32'h0000_0000;
        div_err_s   = 1'b0;
        cache_wr_s  = 1'b0;
        cache_inv_s = 1'b0;
        if (flush) begin
            state_s     = IDLE;
            cnt_s       = '0;
            cache_inv_s = (state_r == WAIT_BUSY) || (state_r == WAIT_DONE);
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && fast_s) begin
                        state_s   = WB;
                        wb_we_s   = (rd_addr != 5'd0);
                        wb_addr_s = rd_addr;
                        wb_data_s = pick_result(func3, fast_quot_s, fast_rem_s);
                    end else if (req_valid) begin
                        state_s  = ISSUE;
                        div_en_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ISSUE: begin
                    state_s = WAIT_BUSY;
                    cnt_s   = '0;
                end
                WAIT_BUSY: begin
                    if (div_busy) begin
                        state_s = WAIT_DONE;
                        cnt_s   = '0;
                    end else if (cnt_r == BUSY_LAST) begin
                        state_s     = WB;
                        cnt_s       = '0;
                        wb_we_s     = (rd_addr_r != 5'd0);
                        wb_addr_s   = rd_addr_r;
                        div_err_s   = 1'b1;
                        cache_inv_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!div_busy) begin
                        state_s    = WB;
                        cnt_s      = '0;
                        wb_we_s    = (rd_addr_r != 5'd0);
                        wb_addr_s  = rd_addr_r;
                        wb_data_s  = pick_result(div_func3, div_quot, div_rem);
                        cache_wr_s = 1'b1;
                    end else if (cnt_r == DONE_LAST) begin
                        state_s     = WB;
                        cnt_s       = '0;
                        wb_we_s     = (rd_addr_r != 5'd0);
                        wb_addr_s   = rd_addr_r;
                        div_err_s   = 1'b1;
                        cache_inv_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                WB: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State, timeout counter and registered control/write-back outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            div_en  <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 32'h0000_0000;
            div_err <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            div_en  <= div_en_s;
            wb_we   <= wb_we_s;
            wb_addr <= wb_addr_s;
            wb_data <= wb_data_s;
            div_err <= div_err_s;
        end
    end

    // Request capture; these registers double as the divider operand outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_op1   <= 32'h0000_0000;
            div_op2   <= 32'h0000_0000;
            div_func3 <= 3'b000;
            rd_addr_r <= 5'd0;
        end else if (take_s) begin
            div_op1   <= op1;
            div_op2   <= op2;
            div_func3 <= func3;
            rd_addr_r <= rd_addr;
        end
    end

    // One-entry result cache; invalidation wins over a same-cycle write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid_r    <= 1'b0;
            cache_op1_r      <= 32'h0000_0000;
            cache_op2_r      <= 32'h0000_0000;
            cache_unsigned_r <= 1'b0;
            cache_quot_r     <= 32'h0000_0000;
            cache_rem_r      <= 32'h0000_0000;
        end else if (cache_inv_s) begin
            cache_valid_r <= 1'b0;
        end else if (cache_wr_s) begin
            cache_valid_r    <= 1'b1;
            cache_op1_r      <= div_op1;
            cache_op2_r      <= div_op2;
            cache_unsigned_r <= div_func3[0];
            cache_quot_r     <= div_quot;
            cache_rem_r      <= div_rem;
        end
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  asynchronous reset, active-low.
REQ-002 SHALL have ports: req_valid  in  1  EX-stage M-divide request; func3  in  3  DIV=100, DIVU=101, REM=110, REMU=111; op1, op2  in  32  dividend, divisor; rd_addr  in  5  destination.
REQ-003 SHALL have ports: flush  in  1  pipeline flush/jump; hold_req  out  1  stall request to pipeline control.
REQ-004 SHALL have writeback ports: wb_we  out  1; wb_addr  out  5; wb_data  out  32; div_err  out  1  timeout pulse.
REQ-005 SHALL have divider-side ports: div_en  out  1; div_op1, div_op2  out  32; div_func3  out  3; div_busy  in  1; div_quot, div_rem  in  32.
REQ-006 SHALL have parameters: BUSY_WAIT_MAX, default 4, cycles to wait for div_busy rise; DONE_WAIT_MAX, default 64, cycles to wait for div_busy fall.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, WB.
REQ-008 SHALL latch func3, op1, op2, rd_addr when req_valid=1 in IDLE; ignore req_valid in other states.
REQ-009 SHALL take the fast path IDLE->WB when: op2==0; or func3[0]=0, op1==0x80000000 and op2==0xFFFFFFFF; or cache hit.
REQ-010 SHALL produce for op2==0: quotient 0xFFFFFFFF, remainder op1. Signed overflow SHALL give quotient 0x80000000, remainder 0.
REQ-011 SHALL define a cache hit as: cache valid, op1 and op2 equal to the cached operands, and func3[0] equal to the cached func3[0]. The stored quotient/remainder SHALL be used on a hit.
REQ-012 SHALL otherwise go IDLE->ISSUE, and in ISSUE assert div_en for exactly one cycle with latched operands/func3 on div_op1/div_op2/div_func3.
REQ-013 SHALL go ISSUE->WAIT_BUSY, then WAIT_BUSY->WAIT_DONE on the first cycle div_busy=1.
REQ-014 SHALL go WAIT_DONE->WB on the first cycle div_busy=0, and capture div_quot/div_rem in that cycle.
REQ-015 SHALL select wb_data: quotient if func3[1]=0, remainder if func3[1]=1.
REQ-016 SHALL, on a normal divider completion, write the cache with operands, func3[0], quotient and remainder; fast-path results SHALL NOT update the cache.
REQ-017 SHALL assert hold_req combinationally when state is IDLE and req_valid=1, and in ISSUE, WAIT_BUSY and WAIT_DONE. hold_req SHALL be 0 in WB.
REQ-018 SHALL, in WB, drive wb_addr and wb_data and assert wb_we for exactly one cycle if rd_addr!=0, then return to IDLE.
REQ-019 SHALL, when WAIT_BUSY exceeds BUSY_WAIT_MAX cycles or WAIT_DONE exceeds DONE_WAIT_MAX cycles, go to WB with wb_data=0, pulse div_err with WB, and invalidate the cache.
REQ-020 SHALL, on flush=1 in any state, go to IDLE next cycle, with no wb_we and no cache update.
REQ-021 SHALL give flush priority over a same-cycle req_valid in IDLE; the request SHALL be dropped and hold_req=0 that cycle.
REQ-022 SHALL, when flush aborts WAIT_*, ignore the divider's busy fall and invalidate the cache.
REQ-023 SHALL give latency in cycles from request to wb_we: fast path 1; divider path 2 + rise wait + busy duration.

Reset
REQ-024 SHALL, on rst=0 asynchronously, force state IDLE and clear to 0: hold_req, div_en, wb_we, wb_addr, wb_data, div_err, div_op1, div_op2, div_func3, the timeout counter and cache valid.
REQ-025 SHALL, on reset mid-operation, discard the result and ignore any later div_busy fall.

Structure
REQ-026 SHALL take the func3 encodings from the shared ins_defines include. State encoding and the overflow constants 0x80000000/0xFFFFFFFF SHALL be local parameters.
REQ-027 SHALL be a single module; the divider is external and instantiated by the EX stage.

Verification
REQ-028 DIVU with op1=100, op2=7, busy high 33 cycles -> wb_data=14, wb_we one cycle, hold_req high every cycle before it.
REQ-029 REM with op1=0xFFFFFF9C (-100), op2=7 -> divider path, wb_data=0xFFFFFFFE (-2). A following DIV with the same operands -> cache hit, wb_data=0xFFFFFFF2 (-14), one cycle later, div_en not pulsed.
REQ-030 DIV with op2=0, op1=5 -> wb_data=0xFFFFFFFF after one cycle. REM with op1=0x80000000, op2=0xFFFFFFFF -> wb_data=0. Neither pulses div_en.
REQ-031 flush in the third WAIT_DONE cycle -> IDLE next cycle, no wb_we, the later busy fall ignored, and a subsequent identical request re-issues div_en.
REQ-032 div_busy never rises after div_en -> WB after BUSY_WAIT_MAX cycles, div_err=1, wb_data=0. Also rst low mid-WAIT_DONE -> all outputs 0 immediately.
